// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU/UART front-end sequencer: FSM state
//   encoding, the one-hot ALU load strobes and small state helpers.
//   No ports (package). Optional feature macro used by the top:
//   ALU_SEQ_TIMEOUT_EN.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam logic [2:0] LOAD_NONE = 3'b000;
  localparam logic [2:0] LOAD_A    = 3'b001;
  localparam logic [2:0] LOAD_B    = 3'b010;
  localparam logic [2:0] LOAD_OP   = 3'b100;

  // True in the three byte-collecting states.
  function automatic logic is_collect(input state_e st);
    return (st == ST_WAIT_A) || (st == ST_WAIT_B) || (st == ST_WAIT_OP);
  endfunction

  // ALU load strobe for the byte accepted in a collecting state.
  function automatic logic [2:0] load_strobe(input state_e st);
    case (st)
      ST_WAIT_A:  return LOAD_A;
      ST_WAIT_B:  return LOAD_B;
      ST_WAIT_OP: return LOAD_OP;
      default:    return LOAD_NONE;
    endcase
  endfunction

  // Successor of a collecting state once its byte is accepted.
  function automatic state_e next_collect(input state_e st);
    case (st)
      ST_WAIT_A: return ST_WAIT_B;
      ST_WAIT_B: return ST_WAIT_OP;
      default:   return ST_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// alu_seq_watchdog
//   Clearable, enabled up-counter with a terminal indication. o_term is
//   high in the cycle where the LIMIT-th consecutive enabled, uncleared
//   cycle is in progress, so the owner can act on the same edge.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-low reset
//   i_en     count enable
//   i_clr    synchronous clear (wins over enable)
//   o_term   terminal count reached (combinational, qualified by i_en)
module alu_seq_watchdog #(
  parameter int LIMIT = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_term
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  assign o_term = i_en && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      cnt <= '0;
    else if (i_clr)
      cnt <= '0;
    else if (i_en && !o_term)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
//   Collects operand A, operand B and an opcode byte from the UART
//   receiver, loads each into the ALU with a one-hot strobe, waits for the
//   ALU result, then hands it to the UART transmitter with a start/busy
//   handshake.
//   Optional macro ALU_SEQ_TIMEOUT_EN adds an inter-byte watchdog that
//   abandons a partial triple after TIMEOUT_CYCLES idle cycles.
// Ports:
//   i_clock       rising-edge clock
//   i_reset       asynchronous active-low reset
//   i_rx_data     byte from UART receiver
//   i_rx_valid    one-cycle strobe, i_rx_data valid
//   o_alu_data    registered data to ALU i_data
//   o_alu_valid   one-hot load strobe: 001=A, 010=B, 100=opcode
//   i_alu_result  ALU result
//   o_tx_data     captured result for the transmitter
//   o_tx_start    one-cycle transmit request
//   i_tx_busy     transmitter busy
//   o_overrun     sticky: byte arrived while not collecting
//   o_timeout     one-cycle pulse on watchdog abort
module alu_uart_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OPERATION   = 6,
  parameter int RESULT_WAIT    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_data,
  output logic [2:0]         o_alu_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  localparam int EXEC_W = $clog2(RESULT_WAIT + 1);
  localparam logic [NB_DATA-1:0] OP_MASK =
    NB_DATA'((64'd1 << NB_OPERATION) - 64'd1);

  state_e            state;
  logic [EXEC_W-1:0] exec_cnt;
  logic              tx_seen_busy;
  logic              collecting;
  logic              wd_term;

  assign collecting = is_collect(state);

`ifdef ALU_SEQ_TIMEOUT_EN
  logic wd_en;

  // Only a partial triple is watched; the idle state waits forever.
  assign wd_en = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

  alu_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (wd_en),
    .i_clr   (!wd_en || i_rx_valid),
    .o_term  (wd_term)
  );
`else
  // Watchdog compiled out: never fires whatever TIMEOUT_CYCLES is.
  assign wd_term = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_WAIT_A;
      exec_cnt     <= '0;
      tx_seen_busy <= 1'b0;
      o_alu_data   <= '0;
      o_alu_valid  <= LOAD_NONE;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_overrun    <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_alu_valid <= LOAD_NONE;
      o_tx_start  <= 1'b0;
      o_timeout   <= 1'b0;

      if (i_rx_valid && !collecting)
        o_overrun <= 1'b1;

      case (state)
        ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP: begin
          // An arriving byte beats a watchdog expiry in the same cycle.
          if (i_rx_valid) begin
            o_alu_valid <= load_strobe(state);
            o_alu_data  <= (state == ST_WAIT_OP) ? (i_rx_data & OP_MASK)
                                                 : i_rx_data;
            exec_cnt    <= '0;
            state       <= next_collect(state);
          end else if (wd_term) begin
            o_timeout <= 1'b1;
            state     <= ST_WAIT_A;
          end
        end
        // Opcode strobe cycle counts as 0; the result is sampled at the
        // end of cycle RESULT_WAIT after it.
        ST_EXEC: begin
          if (exec_cnt == EXEC_W'(RESULT_WAIT)) begin
            o_tx_data <= i_alu_result;
            state     <= ST_SEND;
          end else begin
            exec_cnt <= exec_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (!i_tx_busy) begin
            o_tx_start   <= 1'b1;
            tx_seen_busy <= 1'b0;
            state        <= ST_WAIT_TX;
          end
        end
        // Require a full busy pulse so a slow transmitter that has not yet
        // raised busy is not mistaken for one that has finished.
        ST_WAIT_TX: begin
          if (i_tx_busy)
            tx_seen_busy <= 1'b1;
          else if (tx_seen_busy)
            state <= ST_WAIT_A;
        end
        default: state <= ST_WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer
//   Directed and randomized bench for alu_uart_sequencer. A transaction
//   level reference (bytes collected, absolute cycle of the opcode strobe,
//   transmit handshake progress) predicts every output each cycle; a few
//   literal checks pin the reference itself. Honors ALU_SEQ_TIMEOUT_EN.
module tb_alu_uart_sequencer;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int RW      = 2;
  localparam int TO      = 20;

  logic       i_clock      = 1'b0;
  logic       i_reset      = 1'b0;
  logic [7:0] i_rx_data    = '0;
  logic       i_rx_valid   = 1'b0;
  logic [7:0] i_alu_result = '0;
  logic       i_tx_busy    = 1'b0;
  logic [7:0] o_alu_data;
  logic [2:0] o_alu_valid;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_overrun;
  logic       o_timeout;

  always #5 i_clock = ~i_clock;

  alu_uart_sequencer #(
    .NB_DATA        (NB_DATA),
    .NB_OPERATION   (NB_OP),
    .RESULT_WAIT    (RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_alu_data   (o_alu_data),
    .o_alu_valid  (o_alu_valid),
    .i_alu_result (i_alu_result),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .i_tx_busy    (i_tx_busy),
    .o_overrun    (o_overrun),
    .o_timeout    (o_timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_got;       // bytes of the current triple taken (3 = result phase)
  int         m_op_cyc;    // cycle number of the opcode strobe
  int         m_idle;
  int         m_cyc = 0;
  bit         m_captured, m_started, m_saw_busy;
  logic [2:0] e_valid;
  logic [7:0] e_data, e_txdata;
  logic       e_start, e_overrun, e_timeout;

  task automatic m_reset();
    m_got = 0; m_idle = 0; m_op_cyc = 0;
    m_captured = 0; m_started = 0; m_saw_busy = 0;
    e_valid = '0; e_data = '0; e_txdata = '0;
    e_start = 0; e_overrun = 0; e_timeout = 0;
  endtask

  // Called at each rising edge with the inputs of the cycle just ending
  // (cycle m_cyc); produces the outputs expected in cycle m_cyc+1.
  task automatic m_step();
    e_valid = '0; e_start = 0; e_timeout = 0;
    if (m_got == 3) begin
      if (i_rx_valid) e_overrun = 1;
      if (!m_captured) begin
        if (m_cyc == m_op_cyc + RW) begin
          e_txdata = i_alu_result;
          m_captured = 1;
        end
      end else if (!m_started) begin
        if (!i_tx_busy) begin e_start = 1; m_started = 1; end
      end else if (!m_saw_busy) begin
        m_saw_busy = i_tx_busy;
      end else if (!i_tx_busy) begin
        m_got = 0;
      end
    end else if (i_rx_valid) begin
      e_valid = 3'(1 << m_got);
      e_data  = (m_got == 2) ? 8'(i_rx_data % (1 << NB_OP)) : i_rx_data;
      if (m_got == 2) begin
        m_op_cyc = m_cyc + 1;
        m_captured = 0; m_started = 0; m_saw_busy = 0;
      end
      m_got++;
      m_idle = 0;
    end
`ifdef ALU_SEQ_TIMEOUT_EN
    else if (m_got != 0) begin
      m_idle++;
      if (m_idle == TO) begin m_got = 0; m_idle = 0; e_timeout = 1; end
    end
`endif
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge i_clock or negedge i_reset);
      if (!i_reset) m_reset();
      else begin m_step(); m_cyc++; end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    @(posedge i_clock);
    forever begin
      @(negedge i_clock);
      chk("alu_valid", 32'(o_alu_valid), 32'(e_valid));
      chk("alu_data",  32'(o_alu_data),  32'(e_data));
      chk("tx_start",  32'(o_tx_start),  32'(e_start));
      chk("tx_data",   32'(o_tx_data),   32'(e_txdata));
      chk("overrun",   32'(o_overrun),   32'(e_overrun));
      chk("timeout",   32'(o_timeout),   32'(e_timeout));
      chk("onehot",    32'($countones(o_alu_valid) <= 1), 32'd1);
    end
  end

  // ---------------- environment ----------------
  bit         force_busy = 0;
  bit         hold_res   = 0;
  logic [7:0] res_val    = '0;

  // ALU stub: a fresh random result every cycle unless pinned, so a
  // capture taken in the wrong cycle is visible.
  initial forever begin
    @(posedge i_clock); #1;
    i_alu_result = hold_res ? res_val : 8'($urandom);
  end

  // Transmitter stub: after a start, busy rises within 0..3 cycles and
  // lasts 1..6 cycles; force_busy can hold it high.
  initial begin
    int dly, len;
    dly = 0; len = 0;
    forever begin
      @(posedge i_clock); #2;
      if (o_tx_start) begin dly = $urandom_range(0, 3); len = $urandom_range(1, 6); end
      if (dly > 0) begin dly--; i_tx_busy = force_busy; end
      else if (len > 0) begin len--; i_tx_busy = 1'b1; end
      else i_tx_busy = force_busy;
    end
  end

  task automatic tick();
    @(posedge i_clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && m_got != 0; k++) tick();
    chk("wait_idle", 32'(m_got == 0), 32'd1);
  endtask

  task automatic wait_start(input string nm, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (o_tx_start) begin lat = i; break; end
    end
    chk(nm, 32'(lat != -1), 32'd1);
  endtask

  initial begin
    int lat;
    // Reset state.
    tick(); tick();
    chk("rst_alu_valid", 32'(o_alu_valid), 32'd0);
    chk("rst_alu_data",  32'(o_alu_data),  32'd0);
    chk("rst_tx_data",   32'(o_tx_data),   32'd0);
    chk("rst_tx_start",  32'(o_tx_start),  32'd0);
    chk("rst_overrun",   32'(o_overrun),   32'd0);
    chk("rst_timeout",   32'(o_timeout),   32'd0);
    i_reset = 1'b1;
    tick(); tick();

    // 3, 4, 0x20 with result 7 and idle transmitter.
    hold_res = 1; res_val = 8'd7;
    send_byte(8'd3);
    chk("t1_strobe_a", 32'(o_alu_valid), 32'b001);
    chk("t1_data_a",   32'(o_alu_data),  32'd3);
    send_byte(8'd4);
    chk("t1_strobe_b", 32'(o_alu_valid), 32'b010);
    chk("t1_data_b",   32'(o_alu_data),  32'd4);
    send_byte(8'h20);
    chk("t1_strobe_op", 32'(o_alu_valid), 32'b100);
    chk("t1_data_op",   32'(o_alu_data),  32'h20);
    wait_start("t1_start_seen", lat);
    chk("t1_latency", 32'(lat), 32'(RW + 2));
    chk("t1_tx_data", 32'(o_tx_data), 32'd7);
    hold_res = 0;
    wait_idle();

    // Opcode masking.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hE0);
    chk("t2_op_mask", 32'(o_alu_data), 32'h20);
    wait_idle();

    // Transmitter busy for 50 cycles at send; stray byte -> overrun.
    force_busy = 1;
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h05);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send_byte(8'hAA);
      else tick();
      chk("t3_no_start_busy", 32'(o_tx_start), 32'd0);
    end
    chk("t3_overrun", 32'(o_overrun), 32'd1);
    force_busy = 0;
    wait_start("t3_start_after_busy", lat);
    wait_idle();

    // Reset after A and B: partial triple abandoned, overrun cleared.
    send_byte(8'h11);
    send_byte(8'h22);
    i_reset = 1'b0;
    tick();
    chk("t4_rst_overrun", 32'(o_overrun),   32'd0);
    chk("t4_rst_data",    32'(o_alu_data),  32'd0);
    chk("t4_rst_valid",   32'(o_alu_valid), 32'd0);
    tick();
    i_reset = 1'b1;
    repeat (4) tick();
    send_byte(8'h33);
    chk("t4_new_a", 32'(o_alu_valid), 32'b001);
    send_byte(8'h44);
    send_byte(8'h07);
    wait_idle();

    // Back-to-back bytes.
    i_rx_valid = 1'b1;
    i_rx_data = 8'h5A; tick();
    chk("t6_b2b_a", 32'(o_alu_valid), 32'b001);
    i_rx_data = 8'hA5; tick();
    chk("t6_b2b_b", 32'(o_alu_valid), 32'b010);
    i_rx_data = 8'hFF; tick();
    chk("t6_b2b_op", 32'(o_alu_valid), 32'b100);
    chk("t6_b2b_op_data", 32'(o_alu_data), 32'h3F);
    i_rx_valid = 1'b0;
    wait_idle();

`ifdef ALU_SEQ_TIMEOUT_EN
    // Only A sent: timeout after TO idle cycles, then A again.
    send_byte(8'h01);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (o_timeout) begin lat = i; break; end
    end
    chk("t5_timeout_lat", 32'(lat), 32'(TO));
    send_byte(8'h02);
    chk("t5_after_to_a", 32'(o_alu_valid), 32'b001);
    // Byte in the expiry cycle wins.
    repeat (TO - 1) tick();
    send_byte(8'h03);
    chk("t5_edge_b",  32'(o_alu_valid), 32'b010);
    chk("t5_edge_to", 32'(o_timeout),   32'd0);
    send_byte(8'h04);
    wait_idle();
`endif

    // Randomized traffic with gaps, busy stretches and occasional resets.
    for (int i = 0; i < 500; i++) begin
      int gap;
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 3);
      force_busy = ($urandom_range(0, 11) == 0);
      repeat (gap) tick();
      if ($urandom_range(0, 99) == 0) begin
        i_reset = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
      end
      send_byte(8'($urandom));
    end
    force_busy = 0;
    repeat (5) tick();
    // Top up any partial triple so the last transaction completes.
    while (m_got != 0 && m_got != 3) send_byte(8'($urandom));
    wait_idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Front-end sequencer between the UART receiver/transmitter and the ALU. It collects three bytes from the receiver (operand A, operand B, opcode) and presents each to the ALU with the matching one-hot load strobe. It then captures the ALU result and hands it to the UART transmitter with a start/busy handshake. It is the stage that drives the ALU's `i_data` and `i_valid` inputs.

## Interface
- `NB_DATA`, 8, byte/operand width; matches ALU data width
- `NB_OPERATION`, 6, opcode width; opcode taken from the byte's low `NB_OPERATION` bits
- `RESULT_WAIT`, 2, cycles from opcode strobe to result capture (≥1)
- `TIMEOUT_CYCLES`, 1000000, inter-byte watchdog limit (used only with `ALU_SEQ_TIMEOUT_EN`)

- `i_clock` in 1, system clock; all logic on rising edge
- `i_reset` in 1, one clock; reset is asynchronous and active-low
- `i_rx_data` in NB_DATA, byte from UART receiver
- `i_rx_valid` in 1, one-cycle strobe, `i_rx_data` valid
- `o_alu_data` out NB_DATA, data to ALU `i_data`
- `o_alu_valid` out 3, one-hot load strobe to ALU `i_valid`: 001=A, 010=B, 100=opcode
- `i_alu_result` in NB_DATA, ALU `o_result`
- `o_tx_data` out NB_DATA, result byte to transmitter
- `o_tx_start` out 1, one-cycle transmit request
- `i_tx_busy` in 1, transmitter busy
- `o_overrun` out 1, sticky; a byte arrived while not accepting
- `o_timeout` out 1, one-cycle pulse on watchdog abort

## Operation
- FSM states:
  - `ST_WAIT_A`, `ST_WAIT_B`, `ST_WAIT_OP`: accept a byte on `i_rx_valid` and advance to the next state.
  - `ST_EXEC`: count `RESULT_WAIT` cycles, then latch `i_alu_result` into `o_tx_data` and go to `ST_SEND`.
  - `ST_SEND`: when `i_tx_busy`=0, pulse `o_tx_start` and go to `ST_WAIT_TX`.
  - `ST_WAIT_TX`: wait for `i_tx_busy` to rise, then fall, then go to `ST_WAIT_A`.
- Accepted byte: `o_alu_data` is registered and held until the next accepted byte.
  - A: full byte, strobe 001.
  - B: full byte, strobe 010.
  - Opcode: low `NB_OPERATION` bits zero-extended, strobe 100.
- Every `o_alu_valid` value is one-hot or zero; never two bits set.
- `i_rx_valid` in `ST_EXEC`/`ST_SEND`/`ST_WAIT_TX`: byte dropped, `o_overrun` set.
  - `o_overrun` clears only on reset.
- Reset values:
  - State `ST_WAIT_A`; `o_alu_data`=0; `o_alu_valid`=000.
  - `o_tx_data`=0; `o_tx_start`=0; `o_overrun`=0; `o_timeout`=0; counters=0.
- Reset asserted mid-sequence: partial operands are abandoned; no strobe or `o_tx_start` is emitted after release until new bytes arrive.

## Timing
- `o_alu_valid` is asserted the cycle after `i_rx_valid` and stays high for exactly one cycle. `o_alu_data` is valid in the same cycle.
- Result capture: `RESULT_WAIT` cycles after the opcode strobe cycle.
- `o_tx_start` is asserted no earlier than one cycle after capture and only while `i_tx_busy`=0. If busy, `ST_SEND` holds.
- `i_rx_valid` on consecutive cycles: each byte is accepted; the strobes are back-to-back.
- Full round trip with idle transmitter: `o_tx_start` rises `RESULT_WAIT`+2 cycles after the opcode strobe.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - Counter runs in `ST_WAIT_B`/`ST_WAIT_OP` and clears on each accepted byte.
  - On reaching `TIMEOUT_CYCLES`: return to `ST_WAIT_A` and pulse `o_timeout`. Already-loaded ALU operands are left unchanged.
  - `i_rx_valid` in the expiry cycle wins: the byte is accepted and no timeout fires.
- Undefined: no counter logic; `o_timeout` tied 0; the FSM waits indefinitely.

## Structure
- Package `alu_seq_pkg`: state encoding enum, one-hot load constants (`LOAD_A`=001, `LOAD_B`=010, `LOAD_OP`=100).
- Sub-module `alu_seq_watchdog`: clearable/enable up-counter with terminal pulse, instantiated only under `ALU_SEQ_TIMEOUT_EN`.

## Test plan
- Bytes 3, 4, 0x20 with stub ALU result 7, transmitter idle:
  - Strobes 001/010/100 with data 3/4/0x20.
  - `o_tx_data`=7 and one `o_tx_start` pulse.
- Opcode byte 0xE0 with `NB_OPERATION`=6 -> `o_alu_data`=0x20.
- `i_tx_busy` held high 50 cycles at `ST_SEND` -> no `o_tx_start` until busy falls. Byte sent during this window -> `o_overrun`=1, sequence unaffected.
- `i_reset` low after A and B are loaded, then released; send a full new triple -> only the new triple's strobes and result appear.
- With `ALU_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20:
  - Send only A -> `o_timeout` pulses after 20 idle cycles; next byte is loaded with strobe 001.
  - Byte arriving exactly at cycle 20 -> strobe 010, no timeout.
- Back-to-back `i_rx_valid` for three cycles -> three consecutive one-cycle strobes, never two bits set.
